fmdll_sel_seq: RTL and testbench
================================

FMDLL_SEL_SEQ -- requirements
Module: fmdll_sel_seq

Interface
REQ-001 SHALL provide parameter NW, default 4, width of the N (cycles per sub-period) counter and config field.
REQ-002 SHALL provide parameter MW, default 2, width of the M (sub-periods per frame) counter and config field.
REQ-003 SHALL provide parameter N_DEF, default 4, N value loaded at reset.
REQ-004 SHALL provide parameter M_DEF, default 2, M value loaded at reset.
REQ-005 SHALL have port clk_out  input  1  single clock; all state on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port en  input  1  run request; frames start only while high.
REQ-008 SHALL have port cfg_valid  input  1  new configuration offered.
REQ-009 SHALL have port cfg_n  input  NW  requested N.
REQ-010 SHALL have port cfg_m  input  MW  requested M.
REQ-011 SHALL have port cfg_ready  output  1  configuration can be accepted this cycle.
REQ-012 SHALL have port sel  output  2  clock-path select: 00 inject clk_ext, 10 recirculate, 01 detect.
REQ-013 SHALL have port n_cnt  output  NW  cycle index in sub-period, 1..N; 0 when idle.
REQ-014 SHALL have port m_cnt  output  MW  sub-period index in frame, 1..M; 0 when idle.
REQ-015 SHALL have port frame_done  output  1  high during the last cycle of each frame.
REQ-016 SHALL have port cfg_err  output  1  sticky flag: zero-valued config was offered.

Function
REQ-017 All outputs except cfg_ready SHALL be driven directly from flops; cfg_ready SHALL be decoded from state and counters only.
REQ-018 FSM states SHALL be IDLE and RUN; IDLE drives sel=10, n_cnt=0, m_cnt=0.
REQ-019 IDLE->RUN SHALL occur on the first edge with en=1; that edge loads n_cnt=1, m_cnt=1.
REQ-020 In RUN, n_cnt SHALL increment each cycle and wrap N->1, incrementing m_cnt on wrap; m_cnt SHALL wrap M->1 at frame end.
REQ-021 For M>=2, sel SHALL be 00 throughout sub-period 1, 10 throughout sub-periods 2..M-1, and 01 throughout sub-period M.
REQ-022 For M=1, sel SHALL be 00 for cycles 1..N-1 and 01 on cycle N; for M=1, N=1, sel SHALL be 01.
REQ-023 sel, n_cnt and m_cnt SHALL change on the same edge, so no cycle shows a sel inconsistent with the counters.
REQ-024 At frame end with en=1, the next frame SHALL start on the following edge without a gap, back-to-back.
REQ-025 At frame end with en=0, the FSM SHALL enter IDLE; dropping en mid-frame SHALL NOT truncate the frame.
REQ-026 cfg_ready SHALL be high in IDLE and during the last cycle of a frame (n_cnt==N, m_cnt==M), otherwise low.
REQ-027 On cfg_valid & cfg_ready, nonzero cfg_n and cfg_m SHALL become active N and M from the next frame.
REQ-028 An accepted config with cfg_n==0 or cfg_m==0 SHALL be discarded, leaving N and M unchanged, and SHALL set cfg_err until reset.
REQ-029 Counter compares SHALL be at full NW/MW width; N=2^NW-1 and M=2^MW-1 SHALL be legal with no overflow.

Reset
REQ-030 Asserting rst SHALL, asynchronously: force IDLE, sel=10, n_cnt=0, m_cnt=0, frame_done=0 and cfg_err=0, and load N=N_DEF and M=M_DEF.
REQ-031 Reset mid-frame SHALL abort the frame immediately; after release, operation SHALL resume per REQ-019.

Configuration
REQ-032 With macro FMDLL_SEL_STATS_EN defined, the block SHALL add output frame_count (16 bits), counting completed frames, saturating at 16'hFFFF, and cleared by rst.
REQ-033 Without FMDLL_SEL_STATS_EN, port frame_count and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 N=4, M=3, en held 1 -> sel 00 x4, 10 x4, 01 x4; frame_done on cycle 12; the next frame starts at cycle 13 with sel=00.
REQ-035 N=3, M=1 -> sel 00, 00, 01 repeating; frame_done every 3rd cycle.
REQ-036 Running N=4, M=2, cfg_n=2, cfg_m=3 offered mid-frame -> cfg_ready low until cycle 8; the current frame completes with N=4, M=2; the next frame is 6 cycles long.
REQ-037 cfg_n=0 offered in IDLE -> cfg_err=1 and remains set; N and M keep defaults 4, 2.
REQ-038 en dropped at cycle 3 of an N=4, M=2 frame -> the frame runs to cycle 8, then IDLE with sel=10; rst asserted at cycle 5 of a later frame -> immediate IDLE, counters 0.
REQ-039 With FMDLL_SEL_STATS_EN, 3 completed frames -> frame_count=3.

Source files
------------

// File: rtl/fmdll_sel_seq.sv
// fmdll_sel_seq: frame sequencer for the FM-DLL clock-path select.
// A frame is M sub-periods of N cycles each; sel injects clk_ext during the
// first sub-period, recirculates in the middle ones and detects in the last.
// Optional feature macro: FMDLL_SEL_STATS_EN adds a saturating frame_count.
module fmdll_sel_seq #(
  parameter int NW    = 4,
  parameter int MW    = 2,
  parameter int N_DEF = 4,
  parameter int M_DEF = 2
) (
  input  logic          clk_out,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_valid,
  input  logic [NW-1:0] cfg_n,
  input  logic [MW-1:0] cfg_m,
  output logic          cfg_ready,
  output logic [1:0]    sel,
  output logic [NW-1:0] n_cnt,
  output logic [MW-1:0] m_cnt,
  output logic          frame_done,
  output logic          cfg_err
`ifdef FMDLL_SEL_STATS_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] SEL_INJ = 2'b00;
  localparam logic [1:0] SEL_REC = 2'b10;
  localparam logic [1:0] SEL_DET = 2'b01;

  state_t        state_q, state_d;
  logic [NW-1:0] n_cnt_q, n_cnt_d, n_act_q, n_act_d;
  logic [MW-1:0] m_cnt_q, m_cnt_d, m_act_q, m_act_d;
  logic [1:0]    sel_q, sel_d;
  logic          frame_done_q, frame_done_d;
  logic          cfg_err_q, cfg_err_d;
  logic          last_cyc;

  // Last cycle of the current frame; counters are 0 in IDLE so this is RUN-only.
  assign last_cyc  = (state_q == RUN) && (n_cnt_q == n_act_q) && (m_cnt_q == m_act_q);
  assign cfg_ready = (state_q == IDLE) || last_cyc;

  assign sel        = sel_q;
  assign n_cnt      = n_cnt_q;
  assign m_cnt      = m_cnt_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

  // Next state, counters and config; sel/frame_done are decoded from the
  // *next* counters and *next* active config so they register on the same edge.
  always_comb begin
    state_d      = state_q;
    n_cnt_d      = n_cnt_q;
    m_cnt_d      = m_cnt_q;
    n_act_d      = n_act_q;
    m_act_d      = m_act_q;
    cfg_err_d    = cfg_err_q;
    sel_d        = SEL_REC;
    frame_done_d = 1'b0;

    // Accepted config only lands between frames, so it first applies to the
    // frame that starts on this edge (or the next one out of IDLE).
    if (cfg_valid && cfg_ready) begin
      if ((cfg_n == '0) || (cfg_m == '0)) cfg_err_d = 1'b1;
      else begin
        n_act_d = cfg_n;
        m_act_d = cfg_m;
      end
    end

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          n_cnt_d = NW'(1);
          m_cnt_d = MW'(1);
        end
      end
      default: begin
        if (n_cnt_q == n_act_q) begin
          n_cnt_d = NW'(1);
          if (m_cnt_q == m_act_q) begin
            if (en) m_cnt_d = MW'(1);
            else begin
              state_d = IDLE;
              n_cnt_d = '0;
              m_cnt_d = '0;
            end
          end else begin
            m_cnt_d = m_cnt_q + MW'(1);
          end
        end else begin
          n_cnt_d = n_cnt_q + NW'(1);
        end
      end
    endcase

    if (state_d == RUN) begin
      if (m_act_d == MW'(1))       sel_d = (n_cnt_d == n_act_d) ? SEL_DET : SEL_INJ;
      else if (m_cnt_d == MW'(1))  sel_d = SEL_INJ;
      else if (m_cnt_d == m_act_d) sel_d = SEL_DET;
      else                         sel_d = SEL_REC;
      frame_done_d = (n_cnt_d == n_act_d) && (m_cnt_d == m_act_d);
    end
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      n_cnt_q      <= '0;
      m_cnt_q      <= '0;
      n_act_q      <= NW'(N_DEF);
      m_act_q      <= MW'(M_DEF);
      sel_q        <= SEL_REC;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_cnt_q      <= n_cnt_d;
      m_cnt_q      <= m_cnt_d;
      n_act_q      <= n_act_d;
      m_act_q      <= m_act_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

`ifdef FMDLL_SEL_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  assign frame_count = frame_count_q;

  // Count frames as their last cycle retires; hold at all-ones.
  always_comb begin
    frame_count_d = frame_count_q;
    if (last_cyc && (frame_count_q != 16'hFFFF)) frame_count_d = frame_count_q + 16'd1;
  end

  // Frame counter register.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) frame_count_q <= '0;
    else     frame_count_q <= frame_count_d;
  end
`endif

endmodule

// File: tb/tb_fmdll_sel_seq.sv
// Directed bench for fmdll_sel_seq: frame shapes, config handshake,
// bad-config flag, en drop, mid-frame reset and the widest legal N/M.
module tb_fmdll_sel_seq;
  localparam int NW = 4;
  localparam int MW = 2;

  logic          clk_out = 1'b0;
  logic          rst, en, cfg_valid;
  logic [NW-1:0] cfg_n;
  logic [MW-1:0] cfg_m;
  logic          cfg_ready, frame_done, cfg_err;
  logic [1:0]    sel;
  logic [NW-1:0] n_cnt;
  logic [MW-1:0] m_cnt;
`ifdef FMDLL_SEL_STATS_EN
  logic [15:0]   frame_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_frames = 0;

  fmdll_sel_seq #(.NW(NW), .MW(MW), .N_DEF(4), .M_DEF(2)) dut (
    .clk_out(clk_out), .rst(rst), .en(en), .cfg_valid(cfg_valid),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_ready(cfg_ready), .sel(sel),
    .n_cnt(n_cnt), .m_cnt(m_cnt), .frame_done(frame_done), .cfg_err(cfg_err)
`ifdef FMDLL_SEL_STATS_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk_out = ~clk_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_out);
    @(negedge clk_out);
  endtask

  // Walk one frame of n x m cycles, checking every cycle. Config (cn, cm) is
  // offered from cycle 'off' (0: only on the last cycle when lv=1); en drops
  // at cycle 'drop' (0: never) and takes en_next on the last cycle.
  task automatic run_frame(input int n, input int m, input bit lv,
                           input int cn, input int cm, input int off,
                           input int drop, input bit en_next);
    int last;
    last = n * m;
    for (int c = 1; c <= last; c++) begin
      int en_i, em_i, es;
      cyc();
      en_i = (c - 1) % n + 1;
      em_i = (c - 1) / n + 1;
      if (m == 1)         es = (c == n) ? 1 : 0;
      else if (em_i == 1) es = 0;
      else if (em_i == m) es = 1;
      else                es = 2;
      chk($sformatf("n_cnt %0dx%0d c%0d", n, m, c), 32'(n_cnt), en_i);
      chk($sformatf("m_cnt %0dx%0d c%0d", n, m, c), 32'(m_cnt), em_i);
      chk($sformatf("sel %0dx%0d c%0d", n, m, c), 32'(sel), es);
      chk($sformatf("frame_done %0dx%0d c%0d", n, m, c), 32'(frame_done), (c == last) ? 1 : 0);
      chk($sformatf("cfg_ready %0dx%0d c%0d", n, m, c), 32'(cfg_ready), (c == last) ? 1 : 0);
      if ((off != 0 && c >= off) || (c == last && lv)) begin
        cfg_valid = 1'b1;
        cfg_n = NW'(cn);
        cfg_m = MW'(cm);
      end else begin
        cfg_valid = 1'b0;
      end
      if (c == drop) en = 1'b0;
      if (c == last) begin
        en = en_next;
        exp_frames++;
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " sel"}, 32'(sel), 2);
    chk({tag, " n_cnt"}, 32'(n_cnt), 0);
    chk({tag, " m_cnt"}, 32'(m_cnt), 0);
    chk({tag, " frame_done"}, 32'(frame_done), 0);
    chk({tag, " cfg_ready"}, 32'(cfg_ready), 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_n = '0; cfg_m = '0;
    #12;
    chk_idle("reset");
    chk("reset cfg_err", 32'(cfg_err), 0);
`ifdef FMDLL_SEL_STATS_EN
    chk("reset frame_count", 32'(frame_count), 0);
`endif
    @(negedge clk_out);
    rst = 1'b0;
    cyc();
    chk_idle("idle");

    // Zero N offered in IDLE: flagged and discarded.
    cfg_valid = 1'b1; cfg_n = '0; cfg_m = 2'd3;
    cyc();
    chk("bad cfg err", 32'(cfg_err), 1);
    chk_idle("idle after bad cfg");
    cfg_valid = 1'b0;
    en = 1'b1;

    // Defaults 4x2, then 4x3, then 3x1 twice, back-to-back.
    run_frame(4, 2, 1, 4, 3, 0, 0, 1'b1);
    run_frame(4, 3, 1, 3, 1, 0, 0, 1'b1);
    run_frame(3, 1, 0, 0, 0, 0, 0, 1'b1);
    run_frame(3, 1, 1, 4, 2, 0, 0, 1'b1);
    // 2x3 offered from cycle 2 of a 4x2 frame: ready only on cycle 8.
    run_frame(4, 2, 0, 2, 3, 2, 0, 1'b1);
    run_frame(2, 3, 1, 15, 3, 0, 0, 1'b1);
    chk("cfg_err sticky", 32'(cfg_err), 1);
    // Widest legal N and M.
    run_frame(15, 3, 1, 4, 2, 0, 0, 1'b1);
    // en dropped on cycle 3: frame still runs to cycle 8, then IDLE.
    run_frame(4, 2, 0, 0, 0, 0, 3, 1'b0);
    cyc();
    chk_idle("idle after en drop");
`ifdef FMDLL_SEL_STATS_EN
    chk("frame_count", 32'(frame_count), exp_frames);
`endif

    // New 4x2 frame aborted by reset on cycle 5.
    en = 1'b1;
    repeat (5) cyc();
    chk("pre-rst sel", 32'(sel), 1);
    chk("pre-rst n_cnt", 32'(n_cnt), 1);
    chk("pre-rst m_cnt", 32'(m_cnt), 2);
    #2 rst = 1'b1;
    #1;
    chk_idle("async rst");
    chk("async rst cfg_err", 32'(cfg_err), 0);
    exp_frames = 0;
`ifdef FMDLL_SEL_STATS_EN
    chk("rst frame_count", 32'(frame_count), 0);
`endif
    @(negedge clk_out);
    rst = 1'b0;
    // Resumes with reset defaults 4x2.
    run_frame(4, 2, 0, 0, 0, 0, 0, 1'b1);
    run_frame(4, 2, 0, 0, 0, 0, 0, 1'b1);
    run_frame(4, 2, 0, 0, 0, 0, 0, 1'b0);
    cyc();
    chk_idle("final idle");
`ifdef FMDLL_SEL_STATS_EN
    chk("frame_count 3", 32'(frame_count), 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
